// File: rtl/char_uart_pkg.sv
// char_uart_pkg: definitions shared by the UART character transmitter and
// receiver.
//   - DATA_BITS_DEF : default number of data bits per frame
//   - rx_state_t    : receiver FSM states
//   - baud_period() : baud index -> clocks per bit at 23.04 MHz (13-bit)
package char_uart_pkg;

  localparam int unsigned DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic [12:0] baud_period(input logic [2:0] idx);
    logic [12:0] p;
    case (idx)
      3'd0:    p = 13'd100;
      3'd1:    p = 13'd200;
      3'd2:    p = 13'd400;
      3'd3:    p = 13'd600;
      3'd4:    p = 13'd1200;
      3'd5:    p = 13'd2400;
      default: p = 13'd4800;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/char_rx_if.sv
// char_rx_if: serial-side and character-side signals of the UART receiver.
//   i_rx         : serial line (idles high), async to the system clock
//   i_baud       : baud index
//   o_char       : last received byte
//   o_valid      : one-cycle strobe, o_char updated in the same cycle
//   o_frame_err  : one-cycle strobe, stop bit sampled low
//   o_parity_err : one-cycle strobe, parity mismatch (parity build only)
//   o_busy       : receiver is not idle
// slave  : the receiver side
// master : the side driving the line and consuming characters
interface char_rx_if;
  logic       i_rx;
  logic [2:0] i_baud;
  logic [7:0] o_char;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_parity_err;
  logic       o_busy;

  modport slave (
    input  i_rx, i_baud,
    output o_char, o_valid, o_frame_err, o_parity_err, o_busy
  );

  modport master (
    output i_rx, i_baud,
    input  o_char, o_valid, o_frame_err, o_parity_err, o_busy
  );
endinterface

// File: rtl/char_rx_sync.sv
// rx_sync: multi-flop synchroniser for an asynchronous input.
//   i_clk  : system clock
//   i_rst  : asynchronous active-low reset; all flops reset to 1 (line idle)
//   i_d    : asynchronous input
//   o_q    : synchronised output
// STAGES must be at least 2.
module rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_sync <= '1;
    else        r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/char_rx.sv
// char_rx: UART character receiver, MSB-first frames
// (start 0, DATA_BITS data, [even parity], stop 1), oversampled by the
// 23.04 MHz system clock.
//   i_clk : system clock
//   i_rst : asynchronous active-low reset
//   bus   : char_rx_if.slave (i_rx, i_baud in; o_char, o_valid,
//           o_frame_err, o_parity_err, o_busy out)
// Optional feature: define CHAR_RX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module char_rx
  import char_uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  char_rx_if.slave   bus
);

  logic                 w_rx_s;
  logic                 w_samp;
  rx_state_t            r_state;
  logic [12:0]          r_period;
  logic [12:0]          r_cnt;
  logic [3:0]           r_bits;
  logic [DATA_BITS-1:0] r_shreg;
  logic [7:0]           r_char;
  logic                 r_valid;
  logic                 r_ferr;
`ifdef CHAR_RX_PARITY_EN
  logic                 r_perr;
  logic                 r_par_bad;
`endif

  rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_rx),
    .o_q   (w_rx_s)
  );

  // Full-bit sample point used by DATA, PARITY and STOP
  assign w_samp = (r_cnt == r_period - 13'd1);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_period  <= '0;
      r_cnt     <= '0;
      r_bits    <= '0;
      r_shreg   <= '0;
      r_char    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef CHAR_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef CHAR_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_bits <= '0;
          if (!w_rx_s) begin
            r_state  <= START;
            r_period <= baud_period(bus.i_baud);
          end
        end
        // Half-bit wait re-centres sampling onto the middle of each bit
        START: begin
          if (r_cnt == (r_period >> 1) - 13'd1) begin
            r_cnt   <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
        DATA: begin
          if (w_samp) begin
            r_cnt   <= '0;
            r_shreg <= {r_shreg[DATA_BITS-2:0], w_rx_s};
            if (r_bits == 4'(DATA_BITS - 1)) begin
              r_bits <= '0;
`ifdef CHAR_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bits <= r_bits + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
`ifdef CHAR_RX_PARITY_EN
        // Mismatch is held until the stop outcome so both strobe together
        PARITY: begin
          if (w_samp) begin
            r_cnt     <= '0;
            r_par_bad <= (^r_shreg) != w_rx_s;
            r_state   <= STOP;
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
`endif
        STOP: begin
          if (w_samp) begin
            r_cnt <= '0;
`ifdef CHAR_RX_PARITY_EN
            r_perr <= r_par_bad;
`endif
            if (w_rx_s) begin
              r_char  <= 8'(r_shreg);
              r_valid <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt + 13'd1;
          end
        end
        // A held-low line (break) must not decode as back-to-back frames
        WAIT_HIGH: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_char      = r_char;
  assign bus.o_valid     = r_valid;
  assign bus.o_frame_err = r_ferr;
  assign bus.o_busy      = (r_state != IDLE);
`ifdef CHAR_RX_PARITY_EN
  assign bus.o_parity_err = r_perr;
`else
  assign bus.o_parity_err = 1'b0;
`endif

endmodule

// File: doc/char_rx.md
Name: char_rx

Overview:
- UART character receiver; the downstream peer of the team's character transmitter. It consumes the serial line that the transmitter drives.
- Oversamples the line with the 23.04 MHz system clock and uses the same baud-index table as the transmitter.
- Frame format is MSB-first to match the transmitter: start bit (0), 8 data bits, stop bit (1).
- Presents each received byte with a one-cycle valid strobe and reports framing errors.

Parameters:
- SYNC_STAGES, 2, number of flops in the input synchroniser on i_rx (minimum 2).
- DATA_BITS, 8, data bits per frame.

Ports:
- i_clk  input  1  system clock, 23.04 MHz.
- i_rst  input  1  reset, asynchronous, active-low.
- i_rx  input  1  serial line, idles high, asynchronous to i_clk.
- i_baud  input  3  baud index. Clocks per bit: 0:100, 1:200, 2:400, 3:600, 4:1200, 5:2400, 6:4800, 7:4800.
- o_char  output  8  last received byte; holds until the next good frame.
- o_valid  output  1  one-cycle pulse; o_char is updated in the same cycle.
- o_frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- o_parity_err  output  1  one-cycle parity error pulse (PARITY_EN only, else tied 0).
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: o_char=0, o_valid=0, o_frame_err=0, o_parity_err=0, o_busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Reset is honoured mid-frame: all registers return to reset values immediately. A partially received byte is discarded and no pulse is issued.
- Input path: i_rx passes through SYNC_STAGES flops. All decisions use the synchronised value rx_s.
- Period: 13-bit, looked up from i_baud. i_baud is latched into period_r on the IDLE->START transition; changing i_baud mid-frame has no effect until the next frame.
- Bit counter: 4-bit. Sample counter: 13-bit, cleared on every state change and after every sample.
- IDLE:
  - rx_s==0 -> START, sample counter cleared.
- START (wait for half a bit period):
  - When the counter reaches period_r/2-1, sample rx_s.
  - If 0 -> DATA.
  - If 1 -> glitch; return to IDLE with no pulse.
- DATA:
  - Sample every period_r clocks (counter==period_r-1).
  - Each sample shifts into the shift register LSB-side (shreg<={shreg[6:0],rx_s}), so the first bit received lands in bit 7.
  - After DATA_BITS samples -> STOP (or PARITY when PARITY_EN is defined).
- STOP:
  - Sample at counter==period_r-1.
  - If rx_s==1: o_char<=shreg, o_valid=1 for one cycle, next state IDLE.
  - If rx_s==0: o_frame_err=1 for one cycle, o_char unchanged, next state WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then go to IDLE. This prevents a break condition from being decoded as repeated frames.
- Back-to-back frames: the stop sample falls mid stop bit, so the receiver returns to IDLE about half a bit before the next start edge and catches it without loss.
- o_valid and o_frame_err are mutually exclusive and never asserted for consecutive frames without an intervening IDLE.
- Latency: o_valid is asserted SYNC_STAGES + period_r/2 + DATA_BITS*period_r + period_r clocks (±1) after i_rx falls at the start edge.

Optional Feature:
- CHAR_RX_PARITY_EN defined:
  - A PARITY state follows DATA and samples one even-parity bit at period_r.
  - Parity mismatch: o_parity_err pulses for one cycle together with the STOP outcome. On a good stop, o_valid still pulses and o_char still updates.
  - Frame length becomes 11 bits.
- Not defined: no PARITY state, o_parity_err is constant 0, frame length is 10 bits.

Decomposition:
- Package char_uart_pkg:
  - baud-index-to-period function/constant table (13-bit), shared with the transmitter;
  - state enum {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH};
  - DATA_BITS default.
- One sub-module, rx_sync: parameterised multi-flop synchroniser with async active-low reset, resetting to 1.

Test Plan:
- Reset: hold i_rst=0 with i_rx=0 -> all outputs 0, state IDLE; after release with i_rx=1, no pulses.
- Good frame: i_baud=0, send 0xA5 MSB-first -> exactly one o_valid, 952±2 clocks after the start edge, with o_char=0xA5; o_frame_err=0.
- Glitch rejection: i_baud=0, i_rx low for 30 clocks then high -> back in IDLE after 50 clocks, no o_valid, no o_frame_err.
- Framing error: i_baud=1, send 0x3C with the stop bit forced 0 and the line held low 500 clocks -> one o_frame_err pulse, o_char unchanged, o_busy high until the line rises, then IDLE.
- Back-to-back frames at i_baud=6: send 0x00, 0xFF, 0x81 with no idle gap -> three o_valid pulses with o_char=0x00, 0xFF, 0x81; i_baud toggled to 0 mid-frame has no effect on the current frame.
- Reset mid-frame: assert i_rst during DATA bit 4, release, then send 0x5A -> no pulse for the aborted frame; o_char=0x5A on the next o_valid.
